cpu_trace_monitor: RTL and testbench
====================================

CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 16, power of two >= 2, meaning trace buffer entries.
REQ-004 SHALL have parameter TIMEOUT, default 100, meaning maximum RUN cycles before a forced halt.
REQ-005 SHALL have parameter STALL_LIMIT, default 4, meaning consecutive equal-PC cycles that count as a hang.
REQ-006 SHALL have parameter EXIT_INSTR, default 32'h0000000C, meaning the exit-syscall encoding.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1, which begins a run from IDLE.
REQ-010 SHALL have port clear, input, 1, a synchronous return to IDLE that empties the buffer.
REQ-011 SHALL have port pc, input, PC_W, the CPU program counter for the current cycle.
REQ-012 SHALL have port instruction, input, INSTR_W, the fetched instruction for the current cycle.
REQ-013 SHALL have port instr_valid, input, 1, high when instruction is defined and fetched from loaded memory.
REQ-014 SHALL have port rd_idx, input, log2(DEPTH), the readback index, 0 = oldest entry.
REQ-015 SHALL have port rd_pc, output, PC_W, the registered readback PC.
REQ-016 SHALL have port rd_instr, output, INSTR_W, the registered readback instruction.
REQ-017 SHALL have port running, output, 1, high in RUN.
REQ-018 SHALL have port halted, output, 1, high in HALTED.
REQ-019 SHALL have port halt_cause, output, 2, with 0=EXIT, 1=INVALID, 2=STALL, 3=TIMEOUT; valid only while halted.
REQ-020 SHALL have port cycle_count, output, 32, counting RUN cycles.
REQ-021 SHALL have port entries, output, log2(DEPTH)+1, the number of valid trace entries.

Function
REQ-022 SHALL implement the states IDLE, RUN and HALTED.
REQ-023 IDLE SHALL go to RUN on start, on the next edge.
REQ-024 RUN SHALL go to HALTED when any halt condition occurs; HALTED SHALL hold until clear or reset.
REQ-025 In RUN, each cycle SHALL write {pc, instruction} at the write pointer, increment cycle_count, and saturate entries at DEPTH.
REQ-026 The write pointer SHALL wrap modulo DEPTH; when full, the oldest entry SHALL be overwritten.
REQ-027 The halt conditions SHALL be: instr_valid low -> INVALID; instruction == EXIT_INSTR -> EXIT; pc equal to the previous pc for STALL_LIMIT consecutive cycles -> STALL; cycle_count reaching TIMEOUT-1 on a write -> TIMEOUT.
REQ-028 When several halt conditions occur in the same cycle, the priority SHALL be INVALID > EXIT > STALL > TIMEOUT.
REQ-029 The cycle that triggers a halt SHALL itself be recorded, except for an INVALID cycle, which SHALL NOT be written.
REQ-030 The stall counter SHALL reset whenever pc differs from the previous cycle's pc, and on entry to RUN.
REQ-031 Readback SHALL have 1-cycle latency: rd_pc/rd_instr SHALL reflect entry (oldest_ptr + rd_idx) mod DEPTH, registered; oldest_ptr = wr_ptr when full, else 0.
REQ-032 A read with rd_idx >= entries SHALL return zeros.
REQ-033 clear SHALL take priority over start and over halt detection in the same cycle.
REQ-034 Inputs other than clear and rd_idx SHALL be ignored in HALTED.

Reset
REQ-035 Reset SHALL force state IDLE; running=0, halted=0, halt_cause=0, cycle_count=0, entries=0, pointers=0, stall counter=0, rd_pc=0, rd_instr=0.
REQ-036 Reset asserted mid-run SHALL abort the run immediately and asynchronously; the buffer contents need not be cleared, but entries=0 SHALL render them unreadable.

Structure
REQ-037 The state encoding, the halt_cause encodings and the EXIT_INSTR default SHALL live in the shared package cpu_debug_pkg.
REQ-038 The buffer SHALL be a sub-module trace_ram (simple dual-port, one write port, registered read port, DEPTH x (PC_W+INSTR_W)).

Verification
REQ-039 start, then 3 valid cycles with pc 0,4,8 and instruction 0x20080005, then instruction 0x0000000C at pc 12 -> halted=1, cause=0, entries=4, rd_idx 3 -> pc 12.
REQ-040 start, pc 0 then 4, then instr_valid=0 at pc 8 -> halted, cause=1, entries=2, cycle_count=2.
REQ-041 start, pc held at 0x10 with valid instructions -> halted after 4 cycles, cause=2.
REQ-042 start, TIMEOUT=100 with distinct incrementing pcs -> halted after 100 cycles, cause=3, entries=16, rd_idx 0 -> pc of cycle 84.
REQ-043 EXIT and instr_valid=0 in the same cycle -> cause=1; clear and start together in IDLE -> state remains IDLE.
REQ-044 reset pulsed mid-run at cycle 5 -> all outputs 0 within the same cycle; a following start begins a fresh trace with entries=1 after one cycle.

Source files
------------

// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the CPU debug blocks: monitor state encoding,
// halt cause encoding and the default exit-syscall instruction.
package cpu_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } trace_state_e;

    typedef enum logic [1:0] {
        CAUSE_EXIT    = 2'd0,
        CAUSE_INVALID = 2'd1,
        CAUSE_STALL   = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } halt_cause_e;

    localparam logic [31:0] EXIT_INSTR_DEFAULT = 32'h0000000C;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one synchronous write port and one
// registered read port. Contents are not reset; the owner decides which
// locations hold valid data.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store one record per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: one-cycle registered read, returns the old data on a
    // same-address collision.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// CPU trace monitor: while running, records {pc, instruction} every cycle
// into a circular buffer and halts on exit syscall, invalid fetch, a hung
// PC or a cycle budget. The buffer is read back oldest-first by index.
module cpu_trace_monitor
    import cpu_debug_pkg::*;
#(
    parameter int                 PC_W        = 32,
    parameter int                 INSTR_W     = 32,
    parameter int                 DEPTH       = 16,
    parameter int                 TIMEOUT     = 100,
    parameter int                 STALL_LIMIT = 4,
    parameter logic [INSTR_W-1:0] EXIT_INSTR  = INSTR_W'(EXIT_INSTR_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       clear,
    input  logic [PC_W-1:0]            pc,
    input  logic [INSTR_W-1:0]         instruction,
    input  logic                       instr_valid,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [PC_W-1:0]            rd_pc,
    output logic [INSTR_W-1:0]         rd_instr,
    output logic                       running,
    output logic                       halted,
    output logic [1:0]                 halt_cause,
    output logic [31:0]                cycle_count,
    output logic [$clog2(DEPTH):0]     entries
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = PC_W + INSTR_W;

    trace_state_e state_q, state_d;
    halt_cause_e  cause_d;
    logic         halt_now;

    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     entries_q;
    logic [31:0]     cycle_q;
    logic [31:0]     stall_cnt_q;
    logic [PC_W-1:0] prev_pc_q;
    logic [1:0]      cause_q;
    logic            rd_valid_q;

    logic [31:0]   stall_next;
    logic          hit_exit;
    logic          hit_stall;
    logic          hit_timeout;
    logic          do_write;
    logic          restart;
    logic [AW-1:0] oldest_ptr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] ram_rd_data;

    // Halt condition detection and buffer addressing.
    always_comb begin
        // A run of equal PCs counts its first cycle as 1, so a PC held for
        // STALL_LIMIT cycles halts on the STALL_LIMIT-th of them.
        if (stall_cnt_q != 32'd0 && pc == prev_pc_q) begin
            stall_next = stall_cnt_q + 32'd1;
        end else begin
            stall_next = 32'd1;
        end
        hit_exit    = (instruction == EXIT_INSTR);
        hit_stall   = (stall_next == 32'(STALL_LIMIT));
        hit_timeout = (cycle_q == 32'(TIMEOUT - 1));
        do_write    = (state_q == ST_RUN) && !clear && instr_valid;
        restart     = clear || (state_q == ST_IDLE && start);
        oldest_ptr  = (entries_q == (AW+1)'(DEPTH)) ? wr_ptr_q : '0;
        rd_addr     = oldest_ptr + rd_idx;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, halt cause selection and status outputs.
    always_comb begin
        state_d  = state_q;
        cause_d  = CAUSE_EXIT;
        halt_now = 1'b0;
        running  = (state_q == ST_RUN);
        halted   = (state_q == ST_HALTED);
        case (state_q)
            ST_IDLE: begin
                if (!clear && start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (!instr_valid) begin
                    halt_now = 1'b1;
                    cause_d  = CAUSE_INVALID;
                end else if (hit_exit) begin
                    halt_now = 1'b1;
                    cause_d  = CAUSE_EXIT;
                end else if (hit_stall) begin
                    halt_now = 1'b1;
                    cause_d  = CAUSE_STALL;
                end else if (hit_timeout) begin
                    halt_now = 1'b1;
                    cause_d  = CAUSE_TIMEOUT;
                end
                if (halt_now) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Trace bookkeeping: pointer, fill level, cycle and stall counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            entries_q   <= '0;
            cycle_q     <= '0;
            stall_cnt_q <= '0;
            prev_pc_q   <= '0;
            cause_q     <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= ({1'b0, rd_idx} < entries_q);
            if (restart) begin
                wr_ptr_q    <= '0;
                entries_q   <= '0;
                cycle_q     <= '0;
                stall_cnt_q <= '0;
                prev_pc_q   <= '0;
                cause_q     <= '0;
            end else if (state_q == ST_RUN) begin
                if (halt_now) begin
                    cause_q <= cause_d;
                end
                if (do_write) begin
                    wr_ptr_q    <= wr_ptr_q + 1'b1;
                    cycle_q     <= cycle_q + 32'd1;
                    stall_cnt_q <= stall_next;
                    prev_pc_q   <= pc;
                    if (entries_q != (AW+1)'(DEPTH)) begin
                        entries_q <= entries_q + 1'b1;
                    end
                end
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DW),
        .AW    (AW)
    ) u_trace_ram (
        .clk     (clk),
        .we      (do_write),
        .wr_addr (wr_ptr_q),
        .wr_data ({pc, instruction}),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Out-of-range reads and the post-reset state show zeros.
    assign rd_pc       = rd_valid_q ? ram_rd_data[DW-1:INSTR_W] : '0;
    assign rd_instr    = rd_valid_q ? ram_rd_data[INSTR_W-1:0] : '0;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_q;
    assign entries     = entries_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor (default parameters).
module tb_cpu_trace_monitor;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [31:0] NOP = 32'h20080005;
    localparam logic [31:0] EXI = 32'h0000000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        clear;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [AW-1:0] rd_idx;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic        running;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;
    logic [AW:0] entries;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_q[$];
    logic [63:0] exp_q[$];

    typedef struct {
        logic        begin_run;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        exp_running;
        logic        exp_halted;
        logic [1:0]  exp_cause;
        logic [31:0] exp_cycles;
        logic [4:0]  exp_entries;
        logic        readback;
    } vec_t;

    vec_t vecs[$];

    cpu_trace_monitor #(
        .PC_W        (32),
        .INSTR_W     (32),
        .DEPTH       (DEPTH),
        .TIMEOUT     (100),
        .STALL_LIMIT (4),
        .EXIT_INSTR  (32'h0000000C)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clear       (clear),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .rd_idx      (rd_idx),
        .rd_pc       (rd_pc),
        .rd_instr    (rd_instr),
        .running     (running),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count),
        .entries     (entries)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic b, input logic [31:0] p, input logic [31:0] i, input logic v,
                       input logic er, input logic eh, input logic [1:0] ec,
                       input logic [31:0] ecy, input logic [4:0] een, input logic rb);
        vec_t t;
        t.begin_run = b; t.pc = p; t.instr = i; t.valid = v;
        t.exp_running = er; t.exp_halted = eh; t.exp_cause = ec;
        t.exp_cycles = ecy; t.exp_entries = een; t.readback = rb;
        vecs.push_back(t);
    endtask

    // Return to IDLE, then start a run; the model buffer is emptied.
    task automatic begin_run();
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        model_q.delete();
    endtask

    task automatic model_write(input logic [31:0] p, input logic [31:0] i);
        model_q.push_back({p, i});
        if (model_q.size() > DEPTH) begin
            void'(model_q.pop_front());
        end
    endtask

    // Read every index once; expectations come from the model buffer.
    task automatic check_readback(input string tag);
        logic [63:0] e;
        logic [63:0] got;
        for (int k = 0; k < DEPTH; k++) begin
            rd_idx = AW'(k);
            exp_q.push_back((k < model_q.size()) ? model_q[k] : 64'd0);
            step();
            got = {rd_pc, rd_instr};
            e = exp_q.pop_front();
            chk($sformatf("%s_rd%0d", tag, k), got, e);
        end
        rd_idx = '0;
    endtask

    initial begin
        logic run_prev;

        reset = 1'b1; start = 1'b0; clear = 1'b0;
        pc = '0; instruction = NOP; instr_valid = 1'b1; rd_idx = '0;
        #2;
        chk("reset_running", {63'd0, running}, 64'd0);
        chk("reset_halted", {63'd0, halted}, 64'd0);
        chk("reset_cause", {62'd0, halt_cause}, 64'd0);
        chk("reset_cycles", {32'd0, cycle_count}, 64'd0);
        chk("reset_entries", {59'd0, entries}, 64'd0);
        chk("reset_rd", {rd_pc, rd_instr}, 64'd0);
        step(); step();
        reset = 1'b0;
        step();

        // clear and start together in IDLE keep the monitor idle
        clear = 1'b1; start = 1'b1;
        step();
        chk("clrstart_running", {63'd0, running}, 64'd0);
        chk("clrstart_halted", {63'd0, halted}, 64'd0);
        clear = 1'b0; start = 1'b0;
        step();
        chk("clrstart_idle", {63'd0, running}, 64'd0);

        // exit after three instructions, then inputs ignored while halted
        add(1, 32'd0,  NOP, 1, 1, 0, 0, 1, 1, 0);
        add(0, 32'd4,  NOP, 1, 1, 0, 0, 2, 2, 0);
        add(0, 32'd8,  NOP, 1, 1, 0, 0, 3, 3, 0);
        add(0, 32'd12, EXI, 1, 0, 1, 0, 4, 4, 0);
        add(0, 32'd16, NOP, 1, 0, 1, 0, 4, 4, 1);
        // invalid fetch is not recorded
        add(1, 32'd0,  NOP, 1, 1, 0, 0, 1, 1, 0);
        add(0, 32'd4,  NOP, 1, 1, 0, 0, 2, 2, 0);
        add(0, 32'd8,  NOP, 0, 0, 1, 1, 2, 2, 1);
        // invalid beats exit in the same cycle
        add(1, 32'h40, EXI, 0, 0, 1, 1, 0, 0, 1);
        // pc held at 0x10
        add(1, 32'h10, NOP, 1, 1, 0, 0, 1, 1, 0);
        add(0, 32'h10, NOP, 1, 1, 0, 0, 2, 2, 0);
        add(0, 32'h10, NOP, 1, 1, 0, 0, 3, 3, 0);
        add(0, 32'h10, NOP, 1, 0, 1, 2, 4, 4, 1);
        // pc change restarts the stall count
        add(1, 32'h10, NOP, 1, 1, 0, 0, 1, 1, 0);
        add(0, 32'h10, NOP, 1, 1, 0, 0, 2, 2, 0);
        add(0, 32'h10, NOP, 1, 1, 0, 0, 3, 3, 0);
        add(0, 32'h14, NOP, 1, 1, 0, 0, 4, 4, 0);
        add(0, 32'h14, NOP, 1, 1, 0, 0, 5, 5, 0);
        add(0, 32'h14, NOP, 1, 1, 0, 0, 6, 6, 0);
        add(0, 32'h14, NOP, 1, 0, 1, 2, 7, 7, 1);
        // exit beats stall in the same cycle
        add(1, 32'h20, NOP, 1, 1, 0, 0, 1, 1, 0);
        add(0, 32'h20, NOP, 1, 1, 0, 0, 2, 2, 0);
        add(0, 32'h20, NOP, 1, 1, 0, 0, 3, 3, 0);
        add(0, 32'h20, EXI, 1, 0, 1, 0, 4, 4, 1);

        run_prev = 1'b0;
        foreach (vecs[n]) begin
            if (vecs[n].begin_run) begin
                begin_run();
                run_prev = 1'b1;
            end
            pc = vecs[n].pc; instruction = vecs[n].instr; instr_valid = vecs[n].valid;
            if (run_prev && vecs[n].valid) begin
                model_write(vecs[n].pc, vecs[n].instr);
            end
            step();
            chk($sformatf("v%0d_running", n), {63'd0, running}, {63'd0, vecs[n].exp_running});
            chk($sformatf("v%0d_halted", n), {63'd0, halted}, {63'd0, vecs[n].exp_halted});
            if (vecs[n].exp_halted) begin
                chk($sformatf("v%0d_cause", n), {62'd0, halt_cause}, {62'd0, vecs[n].exp_cause});
            end
            chk($sformatf("v%0d_cycles", n), {32'd0, cycle_count}, {32'd0, vecs[n].exp_cycles});
            chk($sformatf("v%0d_entries", n), {59'd0, entries}, {59'd0, vecs[n].exp_entries});
            run_prev = vecs[n].exp_running;
            if (vecs[n].readback) begin
                instr_valid = 1'b1;
                check_readback($sformatf("v%0d", n));
            end
        end

        // timeout with distinct pcs, buffer wraps
        begin_run();
        for (int c = 0; c < 100; c++) begin
            pc = 32'h1000 + 32'(c) * 4;
            instruction = 32'h20000000 + 32'(c);
            instr_valid = 1'b1;
            model_write(pc, instruction);
            step();
            if (c == 98) begin
                chk("to_running_99", {63'd0, running}, 64'd1);
                chk("to_cycles_99", {32'd0, cycle_count}, 64'd99);
            end
        end
        chk("to_halted", {63'd0, halted}, 64'd1);
        chk("to_cause", {62'd0, halt_cause}, 64'd3);
        chk("to_cycles", {32'd0, cycle_count}, 64'd100);
        chk("to_entries", {59'd0, entries}, 64'd16);
        rd_idx = '0;
        step();
        chk("to_oldest_pc", {32'd0, rd_pc}, {32'd0, 32'h1000 + 32'd84 * 4});
        check_readback("to");

        // clear wins over an exit in the same cycle
        begin_run();
        pc = 32'h300; instruction = NOP; instr_valid = 1'b1;
        step();
        pc = 32'h304;
        step();
        clear = 1'b1; pc = 32'h308; instruction = EXI;
        step();
        clear = 1'b0;
        model_q.delete();
        chk("clr_running", {63'd0, running}, 64'd0);
        chk("clr_halted", {63'd0, halted}, 64'd0);
        chk("clr_entries", {59'd0, entries}, 64'd0);
        chk("clr_cycles", {32'd0, cycle_count}, 64'd0);
        step();
        chk("clr_stays_idle", {63'd0, running}, 64'd0);
        check_readback("clr");

        // asynchronous reset in the middle of a run
        begin_run();
        instruction = NOP; instr_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            pc = 32'h100 + 32'(c) * 4;
            step();
        end
        rd_idx = 4'd1;
        step();
        chk("pre_rst_rd", {rd_pc, rd_instr}, {32'h104, NOP});
        #2;
        reset = 1'b1;
        #1;
        chk("rst_running", {63'd0, running}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_cause", {62'd0, halt_cause}, 64'd0);
        chk("rst_cycles", {32'd0, cycle_count}, 64'd0);
        chk("rst_entries", {59'd0, entries}, 64'd0);
        chk("rst_rd", {rd_pc, rd_instr}, 64'd0);
        reset = 1'b0;
        rd_idx = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        model_q.delete();
        pc = 32'h200; instruction = NOP;
        model_write(pc, instruction);
        step();
        chk("post_rst_entries", {59'd0, entries}, 64'd1);
        chk("post_rst_cycles", {32'd0, cycle_count}, 64'd1);
        pc = 32'h204; instruction = EXI;
        model_write(pc, instruction);
        step();
        chk("post_rst_halted", {63'd0, halted}, 64'd1);
        check_readback("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
